// File: rtl/control_sequencer.sv
// Hardwired control unit for the phase-2 CPU datapath: a three-state fetch followed by
// an opcode-dependent execute of up to five states, looping until halt or reset.
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        ZHighOut,
  output logic        ZLowOut,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCin,
  output logic        Rin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  operation,
  output logic        Run
);

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_t     state_reg;
  state_t     state_next;
  logic [4:0] opcode;
  logic       ir_unused;

  logic       is_ld;
  logic       is_ldi;
  logic       is_st;
  logic       is_alu;
  logic       is_imm;
  logic       is_br;
  logic       is_halt;
  logic       is_addr;
  logic [4:0] imm_op;

  assign opcode    = IR[31:27];
  assign ir_unused = ^IR[26:0];

  // Opcode classes; anything not matched falls through as a nop.
  always_comb begin
    is_ld   = 1'b0;
    is_ldi  = 1'b0;
    is_st   = 1'b0;
    is_alu  = 1'b0;
    is_imm  = 1'b0;
    is_br   = 1'b0;
    is_halt = 1'b0;
    imm_op  = 5'b00000;
    case (opcode)
      OP_LD:   is_ld   = 1'b1;
      OP_LDI:  is_ldi  = 1'b1;
      OP_ST:   is_st   = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu = 1'b1;
      OP_ADDI: begin is_imm = 1'b1; imm_op = 5'b00011; end
      OP_ANDI: begin is_imm = 1'b1; imm_op = 5'b00101; end
      OP_ORI:  begin is_imm = 1'b1; imm_op = 5'b00110; end
      OP_BR:   is_br   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
    is_addr = is_ld | is_ldi | is_st;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RST:  state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3: begin
        if (is_halt)
          state_next = ST_HALT;
        else if (is_addr | is_alu | is_imm | is_br)
          state_next = ST_T4;
        else
          state_next = ST_T0;
      end
      ST_T4:   state_next = ST_T5;
      ST_T5:   state_next = (is_ld | is_st | is_br) ? ST_T6 : ST_T0;
      ST_T6:   state_next = (is_ld | is_st) ? ST_T7 : ST_T0;
      ST_T7:   state_next = ST_T0;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr)
      state_reg <= ST_RST;
    else
      state_reg <= state_next;
  end

  // Strobes are decoded from the current state; IR and CON_FF only steer execute states.
  always_comb begin
    PCout     = 1'b0;
    ZHighOut  = 1'b0;
    ZLowOut   = 1'b0;
    MDRout    = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    Cout      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    PCin      = 1'b0;
    Rin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    CONin     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    operation = 5'b00000;
    Run       = 1'b0;
    case (state_reg)
      ST_T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Run     = 1'b1;
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        Run = 1'b1;
        if (is_addr) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (is_alu | is_imm) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_br) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          CONin = 1'b1;
        end
      end
      ST_T4: begin
        Run = 1'b1;
        if (is_addr) begin
          Cout      = 1'b1;
          Zin       = 1'b1;
          operation = ADD_OP;
        end else if (is_alu) begin
          Grc       = 1'b1;
          Rout      = 1'b1;
          Zin       = 1'b1;
          operation = opcode;
        end else if (is_imm) begin
          Cout      = 1'b1;
          Zin       = 1'b1;
          operation = imm_op;
        end else if (is_br) begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end
      end
      ST_T5: begin
        Run = 1'b1;
        if (is_ld | is_st) begin
          ZLowOut = 1'b1;
          MARin   = 1'b1;
        end else if (is_ldi | is_alu | is_imm) begin
          ZLowOut = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end else if (is_br) begin
          Cout      = 1'b1;
          Zin       = 1'b1;
          operation = ADD_OP;
        end
      end
      ST_T6: begin
        Run = 1'b1;
        if (is_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end else if (is_st) begin
          // Read stays low so MDR captures the register value from the bus.
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end else if (is_br && CON_FF) begin
          ZLowOut = 1'b1;
          PCin    = 1'b1;
        end
      end
      ST_T7: begin
        Run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction is expanded into its
// expected per-cycle microprogram and compared cycle by cycle against the DUT.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] IR;
  logic        CON_FF;
  logic PCout, ZHighOut, ZLowOut, MDRout, Rout, BAout, Cout;
  logic MARin, MDRin, IRin, Yin, Zin, PCin, Rin, HIin, LOin, CONin;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] operation;

  control_sequencer #(.ADD_OP(5'b00011)) dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .MDRout(MDRout),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .Rin(Rin), .HIin(HIin),
    .LOin(LOin), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .Read(Read), .Write(Write), .operation(operation), .Run(Run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [28:0] M_PCOUT  = 29'(1) << 22;
  localparam logic [28:0] M_ZHIGH  = 29'(1) << 21;
  localparam logic [28:0] M_ZLOW   = 29'(1) << 20;
  localparam logic [28:0] M_MDROUT = 29'(1) << 19;
  localparam logic [28:0] M_ROUT   = 29'(1) << 18;
  localparam logic [28:0] M_BAOUT  = 29'(1) << 17;
  localparam logic [28:0] M_COUT   = 29'(1) << 16;
  localparam logic [28:0] M_MARIN  = 29'(1) << 15;
  localparam logic [28:0] M_MDRIN  = 29'(1) << 14;
  localparam logic [28:0] M_IRIN   = 29'(1) << 13;
  localparam logic [28:0] M_YIN    = 29'(1) << 12;
  localparam logic [28:0] M_ZIN    = 29'(1) << 11;
  localparam logic [28:0] M_PCIN   = 29'(1) << 10;
  localparam logic [28:0] M_RIN    = 29'(1) << 9;
  localparam logic [28:0] M_GRA    = 29'(1) << 5;
  localparam logic [28:0] M_GRB    = 29'(1) << 4;
  localparam logic [28:0] M_GRC    = 29'(1) << 3;
  localparam logic [28:0] M_INCPC  = 29'(1) << 2;
  localparam logic [28:0] M_READ   = 29'(1) << 1;
  localparam logic [28:0] M_WRITE  = 29'(1) << 0;
  localparam logic [28:0] M_CONIN  = 29'(1) << 6;
  localparam logic [28:0] M_RUN    = 29'(1) << 28;

  logic [28:0] obs;
  assign obs = {Run, operation, PCout, ZHighOut, ZLowOut, MDRout, Rout, BAout, Cout,
                MARin, MDRin, IRin, Yin, Zin, PCin, Rin, HIin, LOin, CONin,
                Gra, Grb, Grc, IncPC, Read, Write};

  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [28:0] got, input logic [28:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [28:0] opf(input logic [4:0] op);
    return 29'(op) << 23;
  endfunction

  // Microprogram of one instruction, fetch included, one entry per clock.
  task automatic plan(input logic [4:0] op, input logic con);
    exp_q.delete();
    exp_q.push_back(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    exp_q.push_back(M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN);
    exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        exp_q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
        exp_q.push_back(M_RUN | M_COUT | M_ZIN | opf(5'b00011));
        if (op == 5'b00001) begin
          exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(M_RUN | M_ZLOW | M_MARIN);
          if (op == 5'b00000) begin
            exp_q.push_back(M_RUN | M_READ | M_MDRIN);
            exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
          end else begin
            exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRIN);
            exp_q.push_back(M_RUN | M_WRITE);
          end
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
        exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | opf(op));
        exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
        exp_q.push_back(M_RUN | M_COUT | M_ZIN |
                        opf(op == 5'b01100 ? 5'b00011 : (op == 5'b01101 ? 5'b00101 : 5'b00110)));
        exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
      end
      5'b10010: begin
        exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CONIN);
        exp_q.push_back(M_RUN | M_PCOUT | M_YIN);
        exp_q.push_back(M_RUN | M_COUT | M_ZIN | opf(5'b00011));
        exp_q.push_back(con ? (M_RUN | M_ZLOW | M_PCIN) : M_RUN);
      end
      default: exp_q.push_back(M_RUN);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting with the DUT in T0; abort_at >= 0 pulls clr low in that step.
  task automatic exec(input logic [31:0] ir, input logic con, input int abort_at);
    int n;
    IR = ir;
    CON_FF = con;
    plan(ir[31:27], con);
    n = exp_q.size();
    for (int s = 0; s < n; s++) begin
      check_eq($sformatf("op%b_T%0d", ir[31:27], s), obs, exp_q[s]);
      if (s == abort_at) begin
        clr = 1'b0;
        tick();
        check_eq("abort_rst", obs, 29'd0);
        clr = 1'b1;
        tick();
        $display("instr ir=%h op=%b con=%0d aborted_at=T%0d", ir, ir[31:27], con, s);
        return;
      end
      tick();
    end
    if (ir[31:27] == 5'b11010) begin
      for (int h = 0; h < 20; h++) begin
        check_eq("halt_hold", obs, 29'd0);
        tick();
      end
      clr = 1'b0;
      tick();
      check_eq("halt_rst", obs, 29'd0);
      clr = 1'b1;
      tick();
    end
    $display("instr ir=%h op=%b con=%0d cycles=%0d", ir, ir[31:27], con, n);
  endtask

  logic [4:0] known_ops [14];
  initial begin
    known_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                  5'b01100, 5'b01101, 5'b01110, 5'b10010, 5'b11001, 5'b11010, 5'b10010};
  end

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    int          ab;
    clr = 1'b0;
    IR = 32'h0;
    CON_FF = 1'b0;
    tick();
    check_eq("reset", obs, 29'd0);
    tick();
    check_eq("reset_hold", obs, 29'd0);
    clr = 1'b1;
    tick();

    exec(32'h0080_0055, 1'b0, -1);        // ld
    exec(32'h1A2B_8000, 1'b0, -1);        // add
    exec(32'h1100_0004, 1'b0, -1);        // st
    exec(32'h9080_0010, 1'b1, -1);        // br taken
    exec(32'h9080_0010, 1'b0, -1);        // br not taken
    exec(32'h0880_0007, 1'b1, -1);        // ldi
    exec(32'h6080_0003, 1'b0, -1);        // addi
    exec(32'h6880_0003, 1'b0, -1);        // andi
    exec(32'h7080_0003, 1'b0, -1);        // ori
    exec(32'h2000_0000, 1'b0, -1);        // sub
    exec(32'hC800_0000, 1'b1, -1);        // nop
    exec(32'hF800_0000, 1'b1, -1);        // unlisted
    exec(32'hD000_0000, 1'b0, -1);        // halt
    exec(32'h0080_0055, 1'b0, 6);         // ld aborted in T6
    exec(32'h1100_0004, 1'b0, 7);         // st aborted in T7
    exec(32'h0080_0055, 1'b0, -1);

    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : known_ops[$urandom_range(0, 13)];
      r[31:27] = op;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      exec(r, 1'($urandom), ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
